// File: rtl/mgnt_pkg.sv
// Shared types for the sys mgnt bus arbiter.
// State encoding, latched request bundle, response sizing.
package mgnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int PORT_W = 3;
  localparam logic [7:0] ERR_BYTE = 8'h00;

  typedef struct packed {
    logic              wr;
    logic [PORT_W-1:0] port;
    logic [7:0]        addr;
  } mreq_t;

  function automatic int nbytes(input int reg_w);
    return reg_w / 8;
  endfunction

endpackage

// File: rtl/mgnt_bus_arbiter_rr_arbiter.sv
// Round-robin pick: first request after last_i, wrapping.
// Emits one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(last_i) + i) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mgnt_bus_arbiter.sv
// Shares the per-port sys mgnt bus between NUM_REQ masters.
// One transaction in flight; read bytes routed to the granted master.
module mgnt_bus_arbiter
  import mgnt_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int NUM_PORT       = 6,
  parameter int MGNT_REG_WIDTH = 32,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_wr_i,
  input  logic [NUM_REQ*PORT_W-1:0] req_port_i,
  input  logic [NUM_REQ*8-1:0]      req_addr_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  output logic [7:0]                resp_data_o,
  output logic                      resp_last_o,
  output logic                      resp_err_o,
  output logic [NUM_PORT-1:0]       sys_req_valid_o,
  output logic                      sys_req_wr_o,
  output logic [7:0]                sys_req_addr_o,
  input  logic                      sys_resp_valid_i,
  input  logic [7:0]                sys_resp_data_i
);

  localparam int NB = nbytes(MGNT_REG_WIDTH);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(NB) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  mreq_t              req_q, req_d, sel_req;
  logic [NUM_REQ-1:0] goh_q, goh_d;
  logic [IW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [NUM_REQ-1:0] rv_q, rv_d;
  logic [7:0]         rd_q, rd_d;
  logic               rl_q, rl_d;
  logic               re_q, re_d;
  logic [NUM_REQ-1:0] arb_oh;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic               port_ok;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (arb_oh),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  always_comb begin
    sel_req = '0;
    for (int m = 0; m < NUM_REQ; m++) begin
      if (arb_oh[m]) begin
        sel_req.wr   = req_wr_i[m];
        sel_req.port = req_port_i[m*PORT_W +: PORT_W];
        sel_req.addr = req_addr_i[m*8 +: 8];
      end
    end
  end

  assign port_ok = int'(req_q.port) < NUM_PORT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      goh_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      tmr_q   <= '0;
      rv_q    <= '0;
      rd_q    <= '0;
      rl_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      goh_q   <= goh_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rl_q    <= rl_d;
      re_q    <= re_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    goh_d   = goh_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    rv_d    = '0;
    rd_d    = '0;
    rl_d    = 1'b0;
    re_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          goh_d   = arb_oh;
          last_d  = arb_idx;
          req_d   = sel_req;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        tmr_d = '0;
        if (req_q.wr) begin
          state_d = ST_IDLE;
        end else if (!port_ok) begin
          rv_d    = goh_q;
          rd_d    = ERR_BYTE;
          rl_d    = 1'b1;
          re_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sys_resp_valid_i) begin
          rv_d  = goh_q;
          rd_d  = sys_resp_data_i;
          cnt_d = cnt_q + 1'b1;
          tmr_d = '0;
          if (cnt_q == CW'(NB - 1)) begin
            rl_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          // Port went silent: close the response with an error byte
          rv_d    = goh_q;
          rd_d    = ERR_BYTE;
          rl_d    = 1'b1;
          re_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o     = '0;
    sys_req_valid_o = '0;
    sys_req_wr_o    = 1'b0;
    sys_req_addr_o  = '0;
    if (state_q == ST_IDLE && rst) begin
      req_ready_o = arb_oh;
    end
    if (state_q == ST_ISSUE && port_ok) begin
      sys_req_valid_o = NUM_PORT'(1) << req_q.port;
      sys_req_wr_o    = req_q.wr;
      sys_req_addr_o  = req_q.addr;
    end
  end

  assign resp_valid_o = rv_q;
  assign resp_data_o  = rd_q;
  assign resp_last_o  = rl_q;
  assign resp_err_o   = re_q;

endmodule

// File: tb/tb_mgnt_bus_arbiter.sv
// Randomized bench for mgnt_bus_arbiter against a transaction-level model.
// Model tracks round-robin grants, byte routing and idle timeout.
module tb_mgnt_bus_arbiter;

  localparam int NR = 2;
  localparam int NP = 6;
  localparam int RW = 32;
  localparam int TO = 16;
  localparam int NB = RW / 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_wr = '0;
  logic [NR*3-1:0] req_port = '0;
  logic [NR*8-1:0] req_addr = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   resp_valid;
  logic [7:0]      resp_data;
  logic            resp_last;
  logic            resp_err;
  logic [NP-1:0]   sys_req_valid;
  logic            sys_req_wr;
  logic [7:0]      sys_req_addr;
  logic            sys_resp_valid = 1'b0;
  logic [7:0]      sys_resp_data = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int last_g;

  always #5 clk = ~clk;

  mgnt_bus_arbiter #(
    .NUM_REQ        (NR),
    .NUM_PORT       (NP),
    .MGNT_REG_WIDTH (RW),
    .TIMEOUT        (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid),
    .req_wr_i         (req_wr),
    .req_port_i       (req_port),
    .req_addr_i       (req_addr),
    .req_ready_o      (req_ready),
    .resp_valid_o     (resp_valid),
    .resp_data_o      (resp_data),
    .resp_last_o      (resp_last),
    .resp_err_o       (resp_err),
    .sys_req_valid_o  (sys_req_valid),
    .sys_req_wr_o     (sys_req_wr),
    .sys_req_addr_o   (sys_req_addr),
    .sys_resp_valid_i (sys_resp_valid),
    .sys_resp_data_i  (sys_resp_data)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] want,
                                 input int last);
    for (int i = 1; i <= NR; i++) begin
      if (want[(last + i) % NR]) return (last + i) % NR;
    end
    return 0;
  endfunction

  task automatic chk_quiet_all(input string tag);
    chk({tag, "_rv"}, resp_valid, 0);
    chk({tag, "_rl"}, resp_last, 0);
    chk({tag, "_re"}, resp_err, 0);
    chk({tag, "_rd"}, resp_data, 0);
    chk({tag, "_sq"}, sys_req_valid, 0);
    chk({tag, "_rdy"}, req_ready, 0);
  endtask

  // Starts and ends on a negedge with the arbiter idle
  task automatic txn(input logic [NR-1:0] want, input logic [NR-1:0] wr,
                     input logic [NR*3-1:0] port,
                     input logic [NR*8-1:0] addr, input int nsend);
    int g, p, cnt, idle, gap;
    bit drive, done;
    logic [7:0] d;
    req_valid = want;
    req_wr    = wr;
    req_port  = port;
    req_addr  = addr;
    #1;
    g = rr_pick(want, last_g);
    chk("grant", req_ready, 32'(1) << g);
    last_g = g;
    p = int'(port[g*3 +: 3]);
    @(negedge clk);
    chk("ready_low", req_ready, 0);
    chk("sysq", sys_req_valid, (p < NP) ? (32'(1) << p) : 32'd0);
    if (p < NP) begin
      chk("sysq_wr", sys_req_wr, wr[g]);
      chk("sysq_addr", sys_req_addr, addr[g*8 +: 8]);
    end
    req_valid = '0;
    if (!wr[g] && $urandom_range(0, 1) == 1) begin
      sys_resp_valid = 1'b1;
      sys_resp_data  = 8'($urandom);
    end
    @(negedge clk);
    sys_resp_valid = 1'b0;
    if (wr[g]) begin
      chk("wr_noresp", resp_valid, 0);
      return;
    end
    if (p >= NP) begin
      chk("bad_v", resp_valid, 32'(1) << g);
      chk("bad_l", resp_last, 1);
      chk("bad_e", resp_err, 1);
      chk("bad_d", resp_data, 0);
      return;
    end
    chk("wait0", resp_valid, 0);
    cnt  = 0;
    idle = 0;
    gap  = $urandom_range(0, TO - 1);
    done = 0;
    while (!done) begin
      drive = (cnt < nsend) && (gap == 0);
      d = 8'($urandom);
      if (drive) begin
        sys_resp_valid = 1'b1;
        sys_resp_data  = d;
        gap = $urandom_range(0, TO - 1);
      end else if (cnt < nsend) begin
        gap--;
      end
      @(negedge clk);
      sys_resp_valid = 1'b0;
      chk("sysq_wait", sys_req_valid, 0);
      if (drive) begin
        chk("byte_v", resp_valid, 32'(1) << g);
        chk("byte_d", resp_data, d);
        chk("byte_l", resp_last, (cnt == NB - 1) ? 1 : 0);
        chk("byte_e", resp_err, 0);
        cnt++;
        idle = 0;
        if (cnt == NB) done = 1;
      end else begin
        idle++;
        if (idle == TO) begin
          chk("to_v", resp_valid, 32'(1) << g);
          chk("to_l", resp_last, 1);
          chk("to_e", resp_err, 1);
          chk("to_d", resp_data, 0);
          done = 1;
        end else begin
          chk("quiet", resp_valid, 0);
        end
      end
    end
    if (nsend < NB) begin
      sys_resp_valid = 1'b1;
      sys_resp_data  = 8'hA5;
      @(negedge clk);
      sys_resp_valid = 1'b0;
      chk("late", resp_valid, 0);
    end
  endtask

  initial begin
    logic [NR-1:0]   w, wr;
    logic [NR*3-1:0] pt;
    logic [NR*8-1:0] ad;
    int ns;
    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    chk_quiet_all("reset");
    req_valid = '0;
    rst = 1'b1;
    last_g = NR - 1;
    @(negedge clk);

    txn(2'b01, 2'b00, {3'd0, 3'd2}, {8'h00, 8'h10}, NB);
    repeat (4) txn(2'b11, 2'b00, {3'd1, 3'd2}, {8'h22, 8'h11}, NB);
    txn(2'b10, 2'b10, {3'd3, 3'd0}, {8'h05, 8'h00}, 0);
    txn(2'b01, 2'b00, {3'd0, 3'd1}, {8'h00, 8'h30}, 2);
    txn(2'b01, 2'b00, {3'd0, 3'd7}, {8'h00, 8'h40}, 0);

    repeat (60) begin
      w  = NR'($urandom_range(1, 3));
      wr = NR'($urandom);
      pt = (NR*3)'($urandom);
      ad = (NR*8)'($urandom);
      ns = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NB - 1) : NB;
      txn(w, wr, pt, ad, ns);
    end

    req_valid = 2'b10;
    req_wr    = 2'b00;
    req_port  = {3'd1, 3'd0};
    #1;
    chk("rst_pre_grant", req_ready, 2'b10);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    sys_resp_valid = 1'b1;
    sys_resp_data  = 8'h3C;
    @(negedge clk);
    sys_resp_valid = 1'b0;
    chk("rst_b1_v", resp_valid, 2'b10);
    chk("rst_b1_d", resp_data, 8'h3C);
    rst = 1'b0;
    #1;
    chk_quiet_all("midrst");
    @(negedge clk);
    rst = 1'b1;
    last_g = NR - 1;
    @(negedge clk);
    chk("post_rst_rv", resp_valid, 0);
    txn(2'b11, 2'b00, {3'd4, 3'd5}, {8'h77, 8'h66}, NB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
